// File: rtl/apb_pkg.sv
// Shared types and address-field constants for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  // Slave slot field addr[15:12] and peripheral region field addr[31:16]
  localparam int SLOT_LSB   = 12;
  localparam int SLOT_W     = 4;
  localparam int REGION_LSB = 16;
  localparam int REGION_W   = 16;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Requester-side handshake plus shared APB bus of the bridge, one bundle.
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);

  logic                    transfer;
  logic [31:0]             addr;
  logic                    write;
  logic [31:0]             wdata;
  logic [31:0]             rdata;
  logic                    ready;
  logic                    err;
  logic                    busy;
  logic [31:0]             PADDR;
  logic                    PWRITE;
  logic                    PENABLE;
  logic [31:0]             PWDATA;
  logic [NUM_SLAVES-1:0]   PSEL;
  logic [32*NUM_SLAVES-1:0] PRDATA_S;
  logic [NUM_SLAVES-1:0]   PREADY_S;

  modport master (
    input  transfer, addr, write, wdata, PRDATA_S, PREADY_S,
    output rdata, ready, err, busy, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

  modport slave (
    output transfer, addr, write, wdata, PRDATA_S, PREADY_S,
    input  rdata, ready, err, busy, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral decode: region match plus slot index and one-hot select.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic [31:0]           addr,
  output logic                  hit,
  output logic [SLOT_W-1:0]     idx,
  output logic [NUM_SLAVES-1:0] sel
);

  always_comb begin
    idx = addr[SLOT_LSB +: SLOT_W];
    hit = (addr[REGION_LSB +: REGION_W] == BASE_ADDR[REGION_LSB +: REGION_W]) &&
          (32'(idx) < NUM_SLAVES);
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = hit && (idx == SLOT_W'(i));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB master: turns one-cycle CPU requests into SETUP/ACCESS transfers with
// address decode, ready/data muxing and an ACCESS-phase timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e            state, state_next;
  logic                  dec_hit, hit_q;
  logic [SLOT_W-1:0]     dec_idx, idx_q;
  logic [NUM_SLAVES-1:0] dec_sel, sel_q;
  logic [CNT_W-1:0]      cnt;
  logic [31:0]           paddr_q, pwdata_q, rdata_q, rdata_mux;
  logic                  pwrite_q, ready_q, err_q;
  logic                  pready_sel, done, done_err;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR)
  ) u_dec (
    .addr (bus.addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .sel  (dec_sel)
  );

  // Only the selected slave's PREADY/PRDATA can ever influence the transfer
  assign pready_sel = |(bus.PREADY_S & sel_q);

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SLOT_W'(i)) rdata_mux = bus.PRDATA_S[32*i +: 32];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_next = state;
    done       = 1'b0;
    done_err   = 1'b0;
    unique case (state)
      IDLE:   if (bus.transfer) state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (!hit_q) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (pready_sel) begin
          done     = 1'b1;
        end else if (cnt == CNT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      sel_q    <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so all registers update from pre-edge values together.
      ready_q <= done;
      if (state == IDLE && bus.transfer) begin
        paddr_q  <= bus.addr;
        pwrite_q <= bus.write;
        pwdata_q <= bus.wdata;
        hit_q    <= dec_hit;
        idx_q    <= dec_idx;
        sel_q    <= dec_sel;
        cnt      <= '0;
      end
      if (state == ACCESS) cnt <= cnt + 1'b1;
      if (done) begin
        err_q   <= done_err;
        rdata_q <= (!done_err && !pwrite_q) ? rdata_mux : '0;
      end
    end
  end

  // Bus strobes are decoded from state so a reset removes them immediately
  assign bus.PSEL    = (state != IDLE) ? sel_q : '0;
  assign bus.PENABLE = (state == ACCESS);
  assign bus.busy    = (state != IDLE);
  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.ready   = ready_q;

endmodule
